if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised fetch-to-decode buffer; successor to the single-entry IF/ID pipeline register. Holds up to `DEPTH` fetched (pc, instruction) pairs in order between the fetch stage and the decoder, so fetch can keep running for several cycles while decode is stalled. Sits between the instruction-fetch unit and `id`. Replaces ad-hoc bubble insertion with a valid/ready handshake, a whole-queue flush on branch/trap redirect, and an occupancy count.

## Interface
Parameters:
- `ADDR_W`, 32, width of pc
- `INST_W`, 32, width of instruction word
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `BUBBLE_INST`, 32'h0000_0000, value driven on `inst_o` when the queue is empty

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pc_i`  in  ADDR_W  pc of the fetched instruction
- `inst_i`  in  INST_W  fetched instruction
- `valid_i`  in  1  fetch presents a valid pair this cycle
- `ready_o`  out  1  queue can accept a pair (not full)
- `stall_i`  in  1  decode cannot consume the head this cycle
- `flush_i`  in  1  discard all entries (branch taken / pipeline flush)
- `pc_o`  out  ADDR_W  pc of head entry
- `inst_o`  out  INST_W  instruction of head entry
- `valid_o`  out  1  head entry is valid
- `count_o`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- Storage: `DEPTH`-entry circular buffer; write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrap modulo `DEPTH`; occupancy register `cnt`.
- `ready_o = (cnt != DEPTH)`; `valid_o = (cnt != 0)`; `count_o = cnt`. All three are decoded from registers only, with no combinational path from any input.
- Head view: if `valid_o`, then `pc_o = mem_pc[rp]` and `inst_o = mem_inst[rp]`. Otherwise `pc_o = 0` and `inst_o = BUBBLE_INST`.
- push = `valid_i && ready_o`: write the pair at `wp`, then `wp <= wp+1`.
- pop = `valid_o && !stall_i`: `rp <= rp+1`.
- Count update: push only gives +1; pop only gives −1; both or neither leave it unchanged.
- Priority, highest first:
  - `rst`: `wp = rp = cnt = 0`.
  - `flush_i`: `wp = rp = cnt = 0`. Any same-cycle push is discarded and any same-cycle pop has no further effect.
  - push/pop as above.
- Full: `ready_o = 0`, so a push is refused even if a pop occurs in the same cycle. There is no full-bypass. Fetch must hold `pc_i`/`inst_i`/`valid_i` until it sees `ready_o`.
- Empty: a push is not forwarded to the outputs in the same cycle (no bypass). Output is the bubble.
- `stall_i` while empty has no effect.
- Storage contents are not reset; only pointers and the count are. Outputs are masked by `valid_o`.

## Timing
- Reset values: `ready_o=1`, `valid_o=0`, `count_o=0`, `pc_o=0`, `inst_o=BUBBLE_INST`.
- Latency: a pair pushed in cycle N appears at the head in cycle N+1 if the queue was empty in cycle N.
- Throughput: one push and one pop per cycle sustained when 0 < cnt < DEPTH.
- Flush in cycle N: in cycle N+1, `valid_o=0`, `count_o=0`, `ready_o=1`. A pair presented in cycle N+1 is accepted normally.
- Reset asserted mid-operation behaves like flush and additionally clears everything at the next edge regardless of other inputs.
- Pointer wrap: after `DEPTH` pushes, `wp` returns to 0. Order must be preserved across the wrap.

## Test plan
- Reset, then idle for 3 cycles → `valid_o=0`, `inst_o=BUBBLE_INST`, `pc_o=0`, `ready_o=1`, `count_o=0` throughout.
- With `stall_i=1`, push pc 0x100, 0x104, 0x108, 0x10C (DEPTH=4) → `count_o` goes 1, 2, 3, 4; `ready_o=0` after the 4th push; a 5th pair (0x110) is held off. Release the stall → head sequence 0x100, 0x104, 0x108, 0x10C, then 0x110 once accepted.
- Continuous push/pop over 10 pairs starting at 0x200 with no stall → `count_o` stays at 1 after the first push; outputs appear in order 0x200..0x224, one per cycle, including across pointer wrap.
- Queue holding 3 entries; assert `flush_i` together with `valid_i` carrying pc 0x300 → next cycle `count_o=0`, `valid_o=0`, and 0x300 is never output. Push 0x400 the next cycle → head is 0x400 one cycle later.
- Full queue with `stall_i=0` and `valid_i=1` in the same cycle → exactly one pop occurs, no push; `count_o` goes 4→3 and `ready_o` rises the following cycle.
- Assert `rst` with 2 entries queued and a push pending → next cycle all outputs equal their reset values.

Source files
------------

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// if_id_queue : in-order (pc, instruction) buffer between fetch and decode
// Revision    : 1.0
// ============================================================================
module if_id_queue #(
  parameter int                 ADDR_W      = 32,
  parameter int                 INST_W      = 32,
  parameter int                 DEPTH       = 4,
  parameter logic [INST_W-1:0]  BUBBLE_INST = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic [INST_W-1:0]          inst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [INST_W-1:0]          inst_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic w_push;
  logic w_pop;

  // Status flags come from the count register only, never from inputs.
  assign ready_o = (cnt_q != CNT_W'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

  assign w_push = valid_i && ready_o;
  assign w_pop  = valid_o && !stall_i;

  assign pc_o   = valid_o ? mem_pc[rp_q]   : '0;
  assign inst_o = valid_o ? mem_inst[rp_q] : BUBBLE_INST;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (w_push) wp_d = wp_q + 1'b1;
      if (w_pop)  rp_d = rp_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage is intentionally unreset; the head view is masked by valid_o.
  always_ff @(posedge clk) begin
    if (w_push && !flush_i && !rst) begin
      mem_pc[wp_q]   <= pc_i;
      mem_inst[wp_q] <= inst_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// Self-checking bench for if_id_queue: queue-based reference model plus directed scenarios.
module tb_if_id_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam logic [INST_W-1:0] BUBBLE = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc_i;
  logic [INST_W-1:0] inst_i;
  logic              valid_i;
  logic              ready_o;
  logic              stall_i;
  logic              flush_i;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_o;
  logic              valid_o;
  logic [CNT_W-1:0]  count_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [ADDR_W+INST_W-1:0] model_q[$];

  if_id_queue #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .BUBBLE_INST(BUBBLE)
  ) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .valid_i(valid_i),
    .ready_o(ready_o), .stall_i(stall_i), .flush_i(flush_i), .pc_o(pc_o),
    .inst_o(inst_o), .valid_o(valid_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [INST_W-1:0] mk_inst(input logic [ADDR_W-1:0] pc);
    return pc ^ 32'hA5C3_0000;
  endfunction

  // Reference: a FIFO of pairs; flags and head follow directly from its size.
  always @(posedge clk) begin
    if (rst || flush_i) begin
      model_q.delete();
    end else begin
      automatic bit rdy = (model_q.size() != DEPTH);
      automatic bit vld = (model_q.size() != 0);
      if (vld && !stall_i) void'(model_q.pop_front());
      if (valid_i && rdy) model_q.push_back({pc_i, inst_i});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit vld = (model_q.size() != 0);
      chk("model_valid", valid_o, vld);
      chk("model_ready", ready_o, model_q.size() != DEPTH);
      chk("model_count", count_o, model_q.size());
      chk("model_pc",    pc_o,   vld ? model_q[0][ADDR_W+INST_W-1:INST_W] : '0);
      chk("model_inst",  inst_o, vld ? model_q[0][INST_W-1:0] : BUBBLE);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [ADDR_W-1:0] pc);
    valid_i = v;
    pc_i    = pc;
    inst_i  = mk_inst(pc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, valid_o, 1'b0);
    chk({tag, "_ready"}, ready_o, 1'b1);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_pc"},    pc_o, 0);
    chk({tag, "_inst"},  inst_o, BUBBLE);
  endtask

  initial begin
    logic [ADDR_W-1:0] heads [5];
    bit accepted;
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk_reset_vals("reset");

    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_vals("idle");
    end

    // Fill under stall, then a fifth pair is held off until space opens.
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 4*i);
      step();
      chk("fill_count", count_o, i + 1);
    end
    chk("full_ready", ready_o, 1'b0);
    drive(1'b1, 32'h110);
    step();
    chk("held_count", count_o, 4);
    stall_i = 1'b0;
    heads[0] = 32'h100; heads[1] = 32'h104; heads[2] = 32'h108;
    heads[3] = 32'h10C; heads[4] = 32'h110;
    for (int k = 0; k < 5; k++) begin
      chk("drain_head", pc_o, heads[k]);
      accepted = valid_i && ready_o;
      step();
      if (accepted) drive(1'b0, '0);
    end
    chk("drain_empty", valid_o, 1'b0);

    // Streaming through the pointer wrap keeps occupancy at one.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h200 + 4*i);
      step();
      chk("stream_head", pc_o, 32'h200 + 4*i);
      chk("stream_count", count_o, 1);
    end
    drive(1'b0, '0);
    step();
    chk("stream_empty", count_o, 0);

    // Flush discards queued entries and the same-cycle push.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h280 + 4*i);
      step();
    end
    chk("preflush_count", count_o, 3);
    drive(1'b1, 32'h300);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk_reset_vals("flush");
    stall_i = 1'b0;
    drive(1'b1, 32'h400);
    step();
    drive(1'b0, '0);
    chk("postflush_head", pc_o, 32'h400);
    chk("postflush_inst", inst_o, mk_inst(32'h400));
    step();
    chk("postflush_empty", valid_o, 1'b0);

    // Full with pop and push together: only the pop happens.
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 4*i);
      step();
    end
    stall_i = 1'b0;
    drive(1'b1, 32'h600);
    step();
    chk("fullpop_count", count_o, 3);
    chk("fullpop_ready", ready_o, 1'b1);
    chk("fullpop_head", pc_o, 32'h504);
    drive(1'b0, '0);
    for (int i = 1; i < 4; i++) begin
      chk("fullpop_drain", pc_o, 32'h500 + 4*i);
      step();
    end
    chk("fullpop_empty", valid_o, 1'b0);

    // Reset mid-operation with a pending push.
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h700 + 4*i);
      step();
    end
    drive(1'b1, 32'h708);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, '0);
    stall_i = 1'b0;
    chk_reset_vals("midrst");

    // Randomized traffic; the model process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, 32'h1000 + 4*n);
      inst_i  = $urandom;
      stall_i = ($urandom_range(0, 2) == 0);
      flush_i = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b0, '0);
    repeat (DEPTH + 1) step();
    chk("final_empty", valid_o, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
